servo_status_sched: RTL and testbench

- Time-multiplexed scheduler for temperature-servo status indicators.
- On each scan strobe, walks NCH error channels through one shared error-classification stage and debounces each channel's 2-bit colour state.
- Drives registered per-channel colour codes and lock flags to the front-panel LED logic.
- Sits between the servo error outputs and the indicator drivers.

---
 rtl/servo_status_pkg.sv | 23 ++
 rtl/servo_status_sched_classify.sv | 53 +++++
 rtl/servo_status_sched.sv | 200 ++++++++++++++++++++
 tb/tb_servo_status_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_status_pkg.sv
// Shared encodings for the servo status scheduler: colour codes, FSM states, error width.
package servo_status_pkg;

  localparam int ERR_W = 16;

  localparam logic [1:0] CLR_LOW   = 2'b00;
  localparam logic [1:0] CLR_SLOW  = 2'b01;
  localparam logic [1:0] CLR_SHIGH = 2'b10;
  localparam logic [1:0] CLR_HIGH  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CLASS  = 2'b01,
    ST_UPDATE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // A channel is "locked" while its error sits inside the range window.
  function automatic logic is_locked(input logic [1:0] clr);
    return (clr == CLR_SLOW) || (clr == CLR_SHIGH);
  endfunction

endpackage

// File: rtl/servo_status_sched_classify.sv
// err_classify: shared error classifier; samples one channel's err/range, presents its class next cycle.
module err_classify
  import servo_status_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ERR_W-1:0] err,
  input  logic [ERR_W-1:0] rng,
  output logic [1:0]       cls
);

  logic [ERR_W-1:0]        err_r;
  logic [ERR_W-1:0]        rng_r;
  logic signed [ERR_W:0]   err_x_s;
  logic signed [ERR_W:0]   rng_x_s;
  logic signed [ERR_W:0]   rng_neg_s;

  // Sample the selected channel; a negative range is clamped to zero on the way in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= {ERR_W{1'b0}};
      rng_r <= {ERR_W{1'b0}};
    end else if (load) begin
      err_r <= err;
      rng_r <= rng[ERR_W-1] ? {ERR_W{1'b0}} : rng;
    end
  end

  // One extra bit keeps -range representable down to -32767
  assign err_x_s   = $signed({err_r[ERR_W-1], err_r});
  assign rng_x_s   = $signed({1'b0, rng_r});
  assign rng_neg_s = -rng_x_s;

  // Four-band classification around zero
  always_comb begin
    cls = CLR_LOW;
    if (err_r[ERR_W-1]) begin
      if (err_x_s < rng_neg_s) begin
        cls = CLR_LOW;
      end else begin
        cls = CLR_SLOW;
      end
    end else begin
      if (err_x_s < rng_x_s) begin
        cls = CLR_SHIGH;
      end else begin
        cls = CLR_HIGH;
      end
    end
  end

endmodule

// File: rtl/servo_status_sched.sv
// servo_status_sched: scans NCH servo errors through one classifier and debounces per-channel colours.
// Optional STATUS_BLINK_EN adds a blink output toggling every BLINK_SCANS completed scans.
module servo_status_sched
  import servo_status_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DEB = 3
`ifdef STATUS_BLINK_EN
  , parameter int BLINK_SCANS = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 scan_tick,
  input  logic [ERR_W*NCH-1:0] err_bus,
  input  logic [ERR_W*NCH-1:0] rng_bus,
  output logic [2*NCH-1:0]     clrst_bus,
  output logic [NCH-1:0]       locked,
  output logic                 busy,
  output logic                 scan_done,
`ifdef STATUS_BLINK_EN
  output logic                 blink,
`endif
  output logic                 overrun
);

  localparam int             CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);
  localparam logic [3:0]     DEB_C   = 4'(DEB);

  state_t           state_r;
  state_t           state_nx_s;
  logic [CHW-1:0]   ch_r;
  logic [ERR_W-1:0] err_sel_s;
  logic [ERR_W-1:0] rng_sel_s;
  logic [1:0]       cls_s;
  logic [1:0]       cand_r [NCH];
  logic [3:0]       cnt_r  [NCH];
  logic [1:0]       clr_r  [NCH];
  logic [NCH-1:0]   locked_r;
  logic [1:0]       cand_nx_s;
  logic [3:0]       cnt_nx_s;
  logic             busy_r, busy_nx_s;
  logic             done_r, done_nx_s;
  logic             overrun_r, overrun_nx_s;

  assign err_sel_s = err_bus[ch_r*ERR_W +: ERR_W];
  assign rng_sel_s = rng_bus[ch_r*ERR_W +: ERR_W];

  err_classify u_classify (
    .clk  (clk),
    .rst  (rst),
    .load (state_r == ST_CLASS),
    .err  (err_sel_s),
    .rng  (rng_sel_s),
    .cls  (cls_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; dropping en abandons the scan from any busy state
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (scan_tick && en) begin
          state_nx_s = ST_CLASS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLASS: begin
        if (en) begin
          state_nx_s = ST_UPDATE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (!en) begin
          state_nx_s = ST_IDLE;
        end else if (ch_r == CH_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CLASS;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs, registered one cycle ahead of the state they describe
  always_comb begin
    busy_nx_s    = (state_nx_s == ST_CLASS) || (state_nx_s == ST_UPDATE);
    done_nx_s    = (state_nx_s == ST_DONE);
    overrun_nx_s = overrun_r | (scan_tick & (state_r != ST_IDLE));
  end

  // Status output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r    <= busy_nx_s;
      done_r    <= done_nx_s;
      overrun_r <= overrun_nx_s;
    end
  end

  // Channel pointer: advances after each update, parked at 0 outside a scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_r <= {CHW{1'b0}};
    end else if ((state_r == ST_UPDATE) && (state_nx_s == ST_CLASS)) begin
      ch_r <= ch_r + CHW'(1);
    end else if ((state_nx_s == ST_IDLE) || (state_nx_s == ST_DONE)) begin
      ch_r <= {CHW{1'b0}};
    end
  end

  // Debounce step for the current channel
  always_comb begin
    cand_nx_s = cls_s;
    cnt_nx_s  = 4'd1;
    if (cls_s == cand_r[ch_r]) begin
      if (cnt_r[ch_r] < DEB_C) begin
        cnt_nx_s = cnt_r[ch_r] + 4'd1;
      end else begin
        cnt_nx_s = cnt_r[ch_r];
      end
    end else begin
      cnt_nx_s = 4'd1;
    end
  end

  // Per-channel debounce state and colour outputs; nothing moves once en drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cand_r[i] <= CLR_LOW;
        cnt_r[i]  <= 4'd0;
        clr_r[i]  <= CLR_LOW;
      end
      locked_r <= {NCH{1'b0}};
    end else if ((state_r == ST_UPDATE) && en) begin
      cand_r[ch_r] <= cand_nx_s;
      cnt_r[ch_r]  <= cnt_nx_s;
      if (cnt_nx_s == DEB_C) begin
        clr_r[ch_r]    <= cand_nx_s;
        locked_r[ch_r] <= is_locked(cand_nx_s);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign clrst_bus[2*g +: 2] = clr_r[g];
  end

  assign locked    = locked_r;
  assign busy      = busy_r;
  assign scan_done = done_r;
  assign overrun   = overrun_r;

`ifdef STATUS_BLINK_EN
  logic [15:0] bcnt_r;
  logic        blink_r;

  // Scan counter and blink phase; both held clear while scanning is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_r  <= 16'd0;
      blink_r <= 1'b0;
    end else if (!en) begin
      bcnt_r  <= 16'd0;
      blink_r <= 1'b0;
    end else if (done_r) begin
      if (bcnt_r == 16'(BLINK_SCANS - 1)) begin
        bcnt_r  <= 16'd0;
        blink_r <= ~blink_r;
      end else begin
        bcnt_r <= bcnt_r + 16'd1;
      end
    end
  end

  assign blink = blink_r;
`endif

endmodule

// File: tb/tb_servo_status_sched.sv
// Bench for servo_status_sched: two instances (DEB=1, DEB=3) against a scan-position behavioural model.
module tb_servo_status_sched;

  localparam int NCH = 4;
  localparam int BS  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         scan_tick = 1'b0;
  logic [63:0]  err_bus = 64'd0;
  logic [63:0]  rng_bus = 64'd0;
  logic [7:0]   clr1, clr3;
  logic [3:0]   lk1, lk3;
  logic         busy1, busy3, done1, done3, ovr1, ovr3;
`ifdef STATUS_BLINK_EN
  logic         blink1, blink3;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  servo_status_sched #(.NCH(NCH), .DEB(1)
`ifdef STATUS_BLINK_EN
    , .BLINK_SCANS(BS)
`endif
  ) u_d1 (
    .clk(clk), .rst(rst), .en(en), .scan_tick(scan_tick),
    .err_bus(err_bus), .rng_bus(rng_bus), .clrst_bus(clr1), .locked(lk1),
    .busy(busy1), .scan_done(done1),
`ifdef STATUS_BLINK_EN
    .blink(blink1),
`endif
    .overrun(ovr1));

  servo_status_sched #(.NCH(NCH), .DEB(3)
`ifdef STATUS_BLINK_EN
    , .BLINK_SCANS(BS)
`endif
  ) u_d3 (
    .clk(clk), .rst(rst), .en(en), .scan_tick(scan_tick),
    .err_bus(err_bus), .rng_bus(rng_bus), .clrst_bus(clr3), .locked(lk3),
    .busy(busy3), .scan_done(done3),
`ifdef STATUS_BLINK_EN
    .blink(blink3),
`endif
    .overrun(ovr3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos: 0 idle, 1..2*NCH position within a scan (odd = sample, even = update), 2*NCH+1 done
  int m_pos, m_e, m_r, m_bcnt;
  bit m_ovr, m_blink;
  int m_cand [2][NCH];
  int m_cnt  [2][NCH];
  int m_clr  [2][NCH];

  function automatic int deb_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cls(input int e, input int r);
    int rr;
    rr = (r < 0) ? 0 : r;
    if (e < 0) return (e < -rr) ? 0 : 1;
    return (e < rr) ? 2 : 3;
  endfunction

  function automatic int nxc(input int c, input int cand, input int cnt, input int d);
    if (c != cand) return 1;
    return (cnt < d) ? cnt + 1 : cnt;
  endfunction

  function automatic logic [7:0] exp_clr(input int k);
    logic [7:0] v;
    for (int i = 0; i < NCH; i++) v[2*i +: 2] = 2'(m_clr[k][i]);
    return v;
  endfunction

  function automatic logic [3:0] exp_lk(input int k);
    logic [3:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (m_clr[k][i] == 1) || (m_clr[k][i] == 2);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos <= 0; m_e <= 0; m_r <= 0; m_ovr <= 1'b0; m_bcnt <= 0; m_blink <= 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NCH; i++) begin
          m_cand[k][i] <= 0; m_cnt[k][i] <= 0; m_clr[k][i] <= 0;
        end
    end else begin
      if (m_pos == 0) begin
        if (scan_tick && en) m_pos <= 1;
      end else begin
        if (scan_tick) m_ovr <= 1'b1;
        if (m_pos == 2*NCH+1 || !en) begin
          m_pos <= 0;
        end else begin
          if (m_pos % 2 == 1) begin
            m_e <= int'($signed(err_bus[((m_pos-1)/2)*16 +: 16]));
            m_r <= int'($signed(rng_bus[((m_pos-1)/2)*16 +: 16]));
          end else begin
            for (int k = 0; k < 2; k++) begin
              m_cand[k][m_pos/2-1] <= cls(m_e, m_r);
              m_cnt[k][m_pos/2-1]  <= nxc(cls(m_e, m_r), m_cand[k][m_pos/2-1], m_cnt[k][m_pos/2-1], deb_of(k));
              if (nxc(cls(m_e, m_r), m_cand[k][m_pos/2-1], m_cnt[k][m_pos/2-1], deb_of(k)) == deb_of(k))
                m_clr[k][m_pos/2-1] <= cls(m_e, m_r);
            end
          end
          m_pos <= m_pos + 1;
        end
      end
      if (!en) begin
        m_bcnt <= 0; m_blink <= 1'b0;
      end else if (m_pos == 2*NCH+1) begin
        if (m_bcnt == BS-1) begin
          m_bcnt <= 0; m_blink <= ~m_blink;
        end else begin
          m_bcnt <= m_bcnt + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("d1_clrst", clr1, exp_clr(0));
      chk("d3_clrst", clr3, exp_clr(1));
      chk("d1_locked", lk1, exp_lk(0));
      chk("d3_locked", lk3, exp_lk(1));
      chk("d1_busy", busy1, (m_pos >= 1 && m_pos <= 2*NCH));
      chk("d3_busy", busy3, (m_pos >= 1 && m_pos <= 2*NCH));
      chk("d1_done", done1, (m_pos == 2*NCH+1));
      chk("d3_done", done3, (m_pos == 2*NCH+1));
      chk("d1_overrun", ovr1, m_ovr);
      chk("d3_overrun", ovr3, m_ovr);
`ifdef STATUS_BLINK_EN
      chk("d1_blink", blink1, m_blink);
      chk("d3_blink", blink3, m_blink);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ch(input int i, input int e, input int r);
    err_bus[i*16 +: 16] = 16'(e);
    rng_bus[i*16 +: 16] = 16'(r);
  endtask

  // One tick, then a fixed window; ot: extra tick cycle, drop: en-low cycle, rst_at: reset cycle
  task automatic run_scan(input int ot, input int drop, input int rst_at, input int exp_lat);
    int lat;
    int ndone;
    lat = 0;
    ndone = 0;
    @(negedge clk);
    scan_tick = 1'b1;
    for (int cyc = 1; cyc <= 2*NCH+4; cyc++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (lat == 0) lat = cyc;
      end
      scan_tick = (cyc == ot);
      if (cyc == drop) en = 1'b0;
      if (cyc == rst_at + 1) rst = 1'b0;
      if (cyc == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_clrst", {24'd0, clr1}, 32'd0);
        chk("async_rst_locked", {28'd0, lk1}, 32'd0);
        chk("async_rst_busy", {31'd0, busy1}, 32'd0);
        chk("async_rst_overrun", {31'd0, ovr1}, 32'd0);
      end
    end
    chk("scan_latency", lat, exp_lat);
    chk("done_pulses", ndone, (exp_lat != 0) ? 1 : 0);
    en = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;
    chk("reset_clrst", clr1, 8'h00);
    chk("reset_busy", busy3, 1'b0);
    chk("reset_overrun", ovr1, 1'b0);
    @(negedge clk);
    en = 1'b1;

    // Basic four-band classification, immediate update
    set_ch(0, -500, 100); set_ch(1, -50, 100); set_ch(2, 50, 100); set_ch(3, 500, 100);
    run_scan(0, 0, 0, 9);
    chk("t1_clrst", clr1, 8'b11100100);
    chk("t1_locked", lk1, 4'b0110);

    // Debounce of three consecutive identical classes
    set_ch(0, -50, 100);
    run_scan(0, 0, 0, 9);
    run_scan(0, 0, 0, 9);
    chk("t2_hold", clr3[1:0], 2'b00);
    run_scan(0, 0, 0, 9);
    chk("t2_commit", clr3[1:0], 2'b01);
    chk("t2_locked", lk3[0], 1'b1);
    set_ch(0, -500, 100);
    run_scan(0, 0, 0, 9);
    run_scan(0, 0, 0, 9);
    set_ch(0, -50, 100);
    run_scan(0, 0, 0, 9);
    chk("t2_glitch", clr3[1:0], 2'b01);

    // Range clamp and extremes
    set_ch(0, 0, -200); set_ch(1, -1, 0); set_ch(2, -32768, 32767); set_ch(3, 32767, 32767);
    run_scan(0, 0, 0, 9);
    chk("t3_bounds", clr1, 8'b11000011);

    // Tick while busy
    run_scan(3, 0, 0, 9);
    chk("t4_overrun", ovr1, 1'b1);

    // en dropped mid-scan: only ch0 reaches its update
    set_ch(0, 50, 100); set_ch(1, -1, 0); set_ch(2, 500, 100); set_ch(3, 50, 100);
    run_scan(0, 4, 0, 0);
    chk("t4_abort", clr1, 8'b11000010);

    // Asynchronous reset mid-scan, then a clean scan
    run_scan(0, 0, 5, 0);
    chk("t5_overrun_clr", ovr1, 1'b0);
    run_scan(0, 0, 0, 9);
    chk("t5_rescan", clr1, 8'b10110010);
    chk("t5_locked", lk1, 4'b1001);

`ifdef STATUS_BLINK_EN
    chk("t6_blink_one", blink1, 1'b0);
    run_scan(0, 0, 0, 9);
    chk("t6_blink_two", blink1, 1'b1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_blink_en_low", blink1, 1'b0);
    en = 1'b1;
`endif

    @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
